// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions. The serial-to-parallel collector and the
// parallel-to-serial output stage use the same frame geometry and slot order.
package fft_pkg;

   localparam int DATA_W      = 16;
   localparam int NUM_SAMPLES = 32;

   typedef logic [DATA_W-1:0]       sample_t;
   typedef sample_t [NUM_SAMPLES-1:0] frame_t;

   // IDLE: no samples, FILL: partial frame, FULL: frame complete and held
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } stp_state_t;

endpackage

// File: rtl/stp_slot_counter.sv
// Write-index counter for the frame collector. Counts stored samples, can be
// flushed, and can reload to 1 when a new frame starts in the same cycle the
// previous one is acknowledged (the incoming sample lands in slot 0).
module stp_slot_counter #(
   parameter int NUM_SAMPLES = 32,
   parameter int CNT_W       = $clog2(NUM_SAMPLES) + 1
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   input  logic             reload_one,
   output logic [CNT_W-1:0] count,
   output logic             terminal
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

   // Count register: clear beats reload, reload beats increment
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (reload_one) begin
         count <= CNT_W'(1);
      end else if (count_enable) begin
         count <= count + 1'b1;
      end
   end

   // Terminal: this enabled increment stores the last sample of the frame
   assign terminal = count_enable && (count == LAST_IDX);

endmodule

// File: rtl/stp_frame_collector.sv
// Serial-to-parallel frame collector feeding the FFT core. Samples arrive one
// per in_strobe and are placed in arrival order (slot 0 first). A completed
// frame is held with frame_ready high until frame_ack; strobes arriving while
// the frame is held are dropped and flagged on the sticky overrun output.
//
// Handshake: in_strobe qualifies serial_in on a single cycle, with no
// backpressure. frame_ready stays high while the frame is held; frame_ack is
// honoured only while frame_ready is high and consumes the frame in that
// cycle. An ack coincident with a strobe starts the next frame with no bubble.
module stp_frame_collector #(
   parameter int DATA_W      = 16,
   parameter int NUM_SAMPLES = 32,
   parameter int CNT_W       = $clog2(NUM_SAMPLES) + 1
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          clear,
   input  logic                          in_strobe,
   input  logic [DATA_W-1:0]             serial_in,
   input  logic                          frame_ack,
   output logic [NUM_SAMPLES*DATA_W-1:0] parallel_out,
   output logic                          frame_ready,
   output logic [CNT_W-1:0]              sample_count,
   output logic                          overrun
);

   import fft_pkg::*;

   localparam int IDX_W = CNT_W - 1;

   stp_state_t                          state;
   stp_state_t                          state_next;
   logic [NUM_SAMPLES-1:0][DATA_W-1:0]  slots;

   logic             cnt_enable;
   logic             cnt_clear;
   logic             cnt_reload;
   logic             cnt_terminal;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic             set_overrun;

   // Plain fill increments are never gated by the FSM decision below, so the
   // counter's terminal flag can feed next-state logic without a loop.
   assign cnt_enable = in_strobe && !clear && (state != FULL);

   stp_slot_counter #(
      .NUM_SAMPLES (NUM_SAMPLES),
      .CNT_W       (CNT_W)
   ) u_slot_counter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (cnt_clear),
      .count_enable (cnt_enable),
      .reload_one   (cnt_reload),
      .count        (sample_count),
      .terminal     (cnt_terminal)
   );

   // Next state, slot write control and counter control
   always_comb begin
      state_next  = state;
      cnt_clear   = clear;
      cnt_reload  = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = sample_count[IDX_W-1:0];
      set_overrun = 1'b0;
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE, FILL: begin
               if (in_strobe) begin
                  wr_en      = 1'b1;
                  state_next = cnt_terminal ? FULL : FILL;
               end
            end
            FULL: begin
               if (frame_ack) begin
                  if (in_strobe) begin
                     cnt_reload = 1'b1;
                     wr_en      = 1'b1;
                     wr_idx     = '0;
                     state_next = FILL;
                  end else begin
                     cnt_clear  = 1'b1;
                     state_next = IDLE;
                  end
               end else if (in_strobe) begin
                  set_overrun = 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // frame_ready tracks entry into FULL as its own register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         frame_ready <= 1'b0;
      end else begin
         frame_ready <= (state_next == FULL);
      end
   end

   // Sticky overrun: set by a strobe into a held frame, cleared only by flush
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         overrun <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
      end else if (set_overrun) begin
         overrun <= 1'b1;
      end
   end

   // Slot storage; contents persist after ack until overwritten
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         slots <= '0;
      end else if (clear) begin
         slots <= '0;
      end else if (wr_en) begin
         slots[wr_idx] <= serial_in;
      end
   end

   assign parallel_out = slots;

endmodule

// File: tb/tb_stp_frame_collector.sv
// Directed bench for stp_frame_collector: table-driven stray-ack vectors plus
// hand-written sequences for fill, hold/overrun, back-to-back, gapped strobes,
// flush and asynchronous reset.
module tb_stp_frame_collector;

   localparam int DATA_W      = 16;
   localparam int NUM_SAMPLES = 32;
   localparam int CNT_W       = $clog2(NUM_SAMPLES) + 1;

   logic                          clk;
   logic                          n_rst;
   logic                          clear;
   logic                          in_strobe;
   logic [DATA_W-1:0]             serial_in;
   logic                          frame_ack;
   logic [NUM_SAMPLES*DATA_W-1:0] parallel_out;
   logic                          frame_ready;
   logic [CNT_W-1:0]              sample_count;
   logic                          overrun;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DATA_W-1:0] exp_q[$];

   typedef struct {
      logic              strobe;
      logic              ack;
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  exp_count;
      logic              exp_ready;
      int                chk_idx;
      logic [DATA_W-1:0] exp_slot;
   } vec_t;

   vec_t vecs[8];

   stp_frame_collector #(
      .DATA_W      (DATA_W),
      .NUM_SAMPLES (NUM_SAMPLES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .in_strobe    (in_strobe),
      .serial_in    (serial_in),
      .frame_ack    (frame_ack),
      .parallel_out (parallel_out),
      .frame_ready  (frame_ready),
      .sample_count (sample_count),
      .overrun      (overrun)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] slot(input int k);
      return parallel_out[k*DATA_W +: DATA_W];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clear     = 1'b0;
      in_strobe = 1'b0;
      frame_ack = 1'b0;
      serial_in = '0;
   endtask

   task automatic strobe(input logic [DATA_W-1:0] d);
      in_strobe = 1'b1;
      serial_in = d;
      tick();
      in_strobe = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      idle_inputs();
      n_rst = 1'b0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("reset_ready", frame_ready, 0);
      check("reset_count", sample_count, 0);
      check("reset_overrun", overrun, 0);
      check("reset_frame_zero", {31'b0, |parallel_out}, 0);
      n_rst = 1'b1;
      tick();

      // ---------------- full frame on consecutive cycles ----------------
      for (int k = 0; k < NUM_SAMPLES; k++) begin
         in_strobe = 1'b1;
         serial_in = 16'h0100 + 16'(k);
         tick();
         check("fill_count", sample_count, k + 1);
         if (k < NUM_SAMPLES - 1) check("fill_ready_early", frame_ready, 0);
      end
      in_strobe = 1'b0;
      check("fill_ready", frame_ready, 1);
      check("fill_slot0", slot(0), 16'h0100);
      check("fill_slot31", slot(31), 16'h011F);
      check("fill_overrun", overrun, 0);

      // ---------------- overrun while held ----------------
      strobe(16'hDEAD);
      check("ovr_slot0", slot(0), 16'h0100);
      check("ovr_slot31", slot(31), 16'h011F);
      check("ovr_flag", overrun, 1);
      check("ovr_ready", frame_ready, 1);
      check("ovr_count", sample_count, 32);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("ack_ready", frame_ready, 0);
      check("ack_count", sample_count, 0);
      check("ack_overrun_sticky", overrun, 1);
      check("ack_slot_retained", slot(0), 16'h0100);
      tick();
      check("overrun_still_set", overrun, 1);
      do_clear();
      check("clear_overrun", overrun, 0);
      check("clear_frame_zero", {31'b0, |parallel_out}, 0);

      // ---------------- back-to-back frames ----------------
      for (int k = 0; k < NUM_SAMPLES; k++) strobe(16'h0200 + 16'(k));
      check("b2b_ready_first", frame_ready, 1);
      frame_ack = 1'b1;
      in_strobe = 1'b1;
      serial_in = 16'hBEEF;
      tick();
      frame_ack = 1'b0;
      in_strobe = 1'b0;
      check("b2b_ready_drop", frame_ready, 0);
      check("b2b_count", sample_count, 1);
      check("b2b_slot0", slot(0), 16'hBEEF);
      check("b2b_slot1_old", slot(1), 16'h0201);
      check("b2b_overrun", overrun, 0);
      for (int k = 1; k < NUM_SAMPLES; k++) begin
         strobe(16'h0300 + 16'(k));
         if (k == NUM_SAMPLES - 2) begin
            check("b2b_ready_early", frame_ready, 0);
            check("b2b_count31", sample_count, 31);
         end
      end
      check("b2b_ready_second", frame_ready, 1);
      check("b2b_count32", sample_count, 32);
      check("b2b_slot0_kept", slot(0), 16'hBEEF);
      check("b2b_slot31", slot(31), 16'h031F);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("b2b_release", frame_ready, 0);

      // ---------------- gapped random strobes ----------------
      for (int k = 0; k < NUM_SAMPLES; k++) begin
         int gap;
         logic [DATA_W-1:0] d;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            tick();
            check("gap_ready_idle", frame_ready, 0);
         end
         d = DATA_W'($urandom_range(0, 16'hFFFF));
         exp_q.push_back(d);
         strobe(d);
         if (k < NUM_SAMPLES - 1) check("gap_ready_early", frame_ready, 0);
      end
      check("gap_ready", frame_ready, 1);
      for (int k = 0; k < NUM_SAMPLES; k++) begin
         logic [DATA_W-1:0] e;
         e = exp_q.pop_front();
         check("gap_slot", slot(k), e);
      end
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;

      // ---------------- clear mid-fill with coincident strobe ----------------
      for (int k = 0; k < 10; k++) strobe(16'h0500 + 16'(k));
      check("mid_count10", sample_count, 10);
      clear     = 1'b1;
      in_strobe = 1'b1;
      serial_in = 16'hAAAA;
      tick();
      clear     = 1'b0;
      in_strobe = 1'b0;
      check("mid_clear_count", sample_count, 0);
      check("mid_clear_frame_zero", {31'b0, |parallel_out}, 0);
      check("mid_clear_ready", frame_ready, 0);
      tick();
      check("mid_clear_count_hold", sample_count, 0);

      // ---------------- asynchronous reset mid-fill ----------------
      for (int k = 0; k < 10; k++) strobe(16'h0600 + 16'(k));
      check("rst_count10", sample_count, 10);
      #2;
      n_rst = 1'b0;
      #1;
      check("async_count", sample_count, 0);
      check("async_frame_zero", {31'b0, |parallel_out}, 0);
      check("async_ready", frame_ready, 0);
      #1;
      n_rst = 1'b1;
      tick();
      check("post_rst_count", sample_count, 0);
      check("post_rst_ready", frame_ready, 0);

      // ---------------- stray ack vectors from IDLE ----------------
      vecs[0] = '{strobe: 1'b0, ack: 1'b1, data: 16'h0000, exp_count: 6'd0, exp_ready: 1'b0, chk_idx: 0, exp_slot: 16'h0000};
      vecs[1] = '{strobe: 1'b1, ack: 1'b0, data: 16'h0A00, exp_count: 6'd1, exp_ready: 1'b0, chk_idx: 0, exp_slot: 16'h0A00};
      vecs[2] = '{strobe: 1'b1, ack: 1'b0, data: 16'h0A01, exp_count: 6'd2, exp_ready: 1'b0, chk_idx: 1, exp_slot: 16'h0A01};
      vecs[3] = '{strobe: 1'b1, ack: 1'b0, data: 16'h0A02, exp_count: 6'd3, exp_ready: 1'b0, chk_idx: 2, exp_slot: 16'h0A02};
      vecs[4] = '{strobe: 1'b1, ack: 1'b0, data: 16'h0A03, exp_count: 6'd4, exp_ready: 1'b0, chk_idx: 3, exp_slot: 16'h0A03};
      vecs[5] = '{strobe: 1'b1, ack: 1'b0, data: 16'h0A04, exp_count: 6'd5, exp_ready: 1'b0, chk_idx: 4, exp_slot: 16'h0A04};
      vecs[6] = '{strobe: 1'b0, ack: 1'b1, data: 16'h0000, exp_count: 6'd5, exp_ready: 1'b0, chk_idx: 4, exp_slot: 16'h0A04};
      vecs[7] = '{strobe: 1'b1, ack: 1'b1, data: 16'h0A05, exp_count: 6'd6, exp_ready: 1'b0, chk_idx: 5, exp_slot: 16'h0A05};
      for (int i = 0; i < 8; i++) begin
         in_strobe = vecs[i].strobe;
         frame_ack = vecs[i].ack;
         serial_in = vecs[i].data;
         tick();
         check("vec_count", sample_count, vecs[i].exp_count);
         check("vec_ready", frame_ready, vecs[i].exp_ready);
         check("vec_slot", slot(vecs[i].chk_idx), vecs[i].exp_slot);
      end
      idle_inputs();
      tick();
      check("vec_slot0_after_acks", slot(0), 16'h0A00);
      check("vec_overrun", overrun, 0);

      // ---------------- final report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
